ldpc_syndrome_check: RTL and testbench
======================================

// Module: ldpc_syndrome_check
// PURPOSE
//  Receive-side companion of the 4320-info/360-parity encoder. Takes the serial hard-decision
//  codeword (4320 info bits, then 360 parity bits), re-accumulates parity from the info bits with
//  the same generator ROM, compares it bit-serially to the received parity and reports pass/fail
//  plus a mismatch count. Info bits are forwarded to the deframer; parity bits are consumed.
// PARAMETERS
//  K_INFO    4320  info bits per frame
//  Z         360   parity width = working-row width = bits per ROM group
//  N_GROUPS  12    ROM rows (K_INFO/Z)
// PORTS
//  clk         in   1    single clock, all flops posedge
//  rst         in   1    asynchronous, active-high reset
//  din_valid   in   1    codeword beat valid
//  din         in   1    hard-decision codeword bit
//  sof         in   1    start of frame; qualified by din_valid, marks info bit 0
//  dout_valid  out  1    forwarded info bit valid
//  dout        out  1    forwarded info bit
//  frame_done  out  1    one-cycle pulse, frame result valid
//  frame_ok    out  1    1 = all 360 parity bits matched; held until next sof
//  err_cnt     out  9    parity mismatch count 0..360; held until next sof
//  busy        out  1    1 in INFO or PARITY
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sum=0, W=0, bit/group counters 0, ROM address 0.
//  FSM: IDLE -(din_valid&sof)-> INFO -(info bit 4319 accepted)-> PARITY
//       -(parity bit 359 accepted)-> DONE -(next cycle)-> IDLE.
//  Beat = cycle with din_valid=1; gaps of any length allowed in INFO/PARITY, counters hold.
//  IDLE/DONE: beats without sof ignored. sof in INFO/PARITY: abort, no frame_done, restart at
//   info bit 0 of the new frame (sum cleared, this beat is bit 0).
//  sof beat clears err_cnt, frame_ok. Reset mid-frame returns to the reset state.
//  INFO, in-group index j (0..359), group g (0..11):
//   E = (j==0) ? rom_out : W;  if din: sum <= sum ^ E;  W <= {E[0],E[359:1]} (rotate right 1).
//   On j==0 beat: ROM address <= g+1 (value at g=11 is don't-care). IDLE keeps address 0.
//   ROM: G_rom4, 4-bit address, 360-bit row, 1-cycle synchronous read latency.
//  PARITY, index k=0..359: received bit compared with sum[359-k]; mismatch -> err_cnt+1.
//   No saturation needed (max 360 fits 9 bits).
//  DONE: frame_done=1 for exactly one cycle, frame_ok=(err_cnt==0), err_cnt final.
//   err_cnt and frame_ok are stable in the frame_done cycle.
//  dout/dout_valid: registered copy of each accepted INFO beat, latency 1 cycle; dout_valid=0 for
//   parity beats and ignored beats. dout=0 whenever dout_valid=0.
//  Simultaneous: sof on the beat that completes parity bit 359 is a new frame; the completing
//   frame's pulse is suppressed (abort rule takes priority).
// STRUCTURE
//  Shared header ldpc_defs.vh: K_INFO, Z, N_GROUPS, N_CW=4680, group boundary constants,
//   FSM state encodings (IDLE/INFO/PARITY/DONE); shared with the encoder.
//  One sub-module: ldpc_parity_acc (sum register, working row W, rotate, XOR, ROM address
//   sequencing, G_rom4 instance). Top holds FSM, counters, comparator and output registers.
// TESTING
//  1 Reset, all-zero 4680-bit frame -> dout 4320 zeros, frame_done once, frame_ok=1, err_cnt=0.
//  2 Random info + parity from encoder golden model, back-to-back frames -> frame_ok=1, err_cnt=0
//    for each frame; dout equals info bits in order, 1-cycle latency.
//  3 Same frame, parity bit k=5 inverted -> frame_ok=0, err_cnt=1; all 360 inverted -> err_cnt=360.
//  4 Info bit 0 inverted (parity unchanged) -> err_cnt = popcount(ROM row 0), frame_ok=0.
//  5 din_valid toggling 1-0 every cycle and random gaps -> results identical to scenario 2.
//  6 sof re-asserted at info bit 1000 -> no frame_done for aborted frame, new frame frame_ok=1;
//    rst pulsed mid-PARITY -> all outputs 0, busy=0, next clean frame passes.

Source files
------------

// File: rtl/ldpc_syndrome_check_pkg.sv
// Shared constants, FSM encoding and generator ROM contents for the 4320/360 LDPC
// encoder and syndrome checker.
package ldpc_syndrome_check_pkg;

    localparam int K_INFO     = 4320;
    localparam int Z          = 360;
    localparam int N_GROUPS   = 12;
    localparam int N_CW       = K_INFO + Z;
    localparam int J_LAST     = Z - 1;
    localparam int G_LAST     = N_GROUPS - 1;
    localparam int K_LAST     = Z - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INFO   = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Generator rows come from one xorshift32 stream, row 0 first, bit 0 first.
    // The loop is nested so that each inner loop stays short during elaboration.
    function automatic logic [N_GROUPS*Z-1:0] gen_rom();
        logic [N_GROUPS*Z-1:0] r;
        logic [31:0]           s;
        r = '0;
        s = 32'h2545_F491;
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int j = 0; j < Z; j++) begin
                s = s ^ (s << 13);
                s = s ^ (s >> 17);
                s = s ^ (s << 5);
                r[g*Z + j] = s[0];
            end
        end
        return r;
    endfunction

    localparam logic [N_GROUPS*Z-1:0] G_ROM = gen_rom();
    localparam logic [Z-1:0]          ROW0  = G_ROM[Z-1:0];

endpackage

// File: rtl/ldpc_parity_acc.sv
// Parity re-accumulator: generator ROM, working row W with right rotation and the
// XOR sum register that must end up equal to the received parity.
module g_rom4
    import ldpc_syndrome_check_pkg::*;
(
    input  logic         clk,
    input  logic [3:0]   addr,
    output logic [Z-1:0] row
);
    always_ff @(posedge clk) begin
        if (addr < 4'(N_GROUPS))
            row <= G_ROM[int'(addr)*Z +: Z];
        else
            row <= '0;
    end
endmodule

module ldpc_parity_acc
    import ldpc_syndrome_check_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         step,
    input  logic         clr,
    input  logic         din,
    input  logic         j_first,
    input  logic [3:0]   grp,
    output logic [Z-1:0] sum
);
    logic [3:0]   addr;
    logic [Z-1:0] rom_out;
    logic [Z-1:0] w;
    logic [Z-1:0] e;
    logic [Z-1:0] e_rot;

    g_rom4 u_rom (
        .clk  (clk),
        .addr (addr),
        .row  (rom_out)
    );

    // Row 0 is taken from the constant, so a restart never waits on the ROM read.
    always_comb begin
        e = w;
        if (start || (j_first && grp == 4'd0))
            e = ROW0;
        else if (j_first)
            e = rom_out;
    end

    assign e_rot = {e[0], e[Z-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            w    <= '0;
            addr <= '0;
        end else if (start) begin
            sum  <= din ? e : '0;
            w    <= e_rot;
            addr <= 4'd1;
        end else if (step) begin
            if (din)
                sum <= sum ^ e;
            w <= e_rot;
            if (j_first)
                addr <= grp + 4'd1;
        end else if (clr) begin
            addr <= '0;
        end
    end
endmodule

// File: rtl/ldpc_syndrome_check.sv
// Receive-side LDPC parity check: forwards info bits, re-accumulates parity and
// counts mismatches against the received parity bits.
//   state    | meaning
//   S_IDLE   | waiting for a sof beat
//   S_INFO   | accepting info bits, forwarding them, accumulating parity
//   S_PARITY | comparing received parity against the accumulated sum
//   S_DONE   | one cycle with frame_done high, then back to S_IDLE
module ldpc_syndrome_check
    import ldpc_syndrome_check_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din,
    input  logic       sof,
    output logic       dout_valid,
    output logic       dout,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [8:0] err_cnt,
    output logic       busy
);
    state_t       state;
    logic [8:0]   j_cnt;
    logic [3:0]   g_cnt;
    logic [8:0]   k_cnt;
    logic [Z-1:0] sum;
    logic         sof_beat;
    logic         info_step;
    logic         acc_clr;
    logic [8:0]   parity_idx;
    logic         mismatch;
    logic [8:0]   err_next;

    assign sof_beat   = din_valid & sof;
    assign info_step  = (state == S_INFO) & din_valid & ~sof;
    assign acc_clr    = (state == S_IDLE) | (state == S_DONE);
    assign parity_idx = 9'(K_LAST) - k_cnt;
    assign mismatch   = (state == S_PARITY) & din_valid & (din != sum[parity_idx]);
    assign err_next   = err_cnt + {8'd0, mismatch};

    ldpc_parity_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .start   (sof_beat),
        .step    (info_step),
        .clr     (acc_clr),
        .din     (din),
        .j_first (j_cnt == 9'd0),
        .grp     (g_cnt),
        .sum     (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            j_cnt      <= '0;
            g_cnt      <= '0;
            k_cnt      <= '0;
            err_cnt    <= '0;
            frame_ok   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= 1'b0;
            // A sof beat restarts from any state, aborting a frame in flight.
            if (sof_beat) begin
                state      <= S_INFO;
                j_cnt      <= 9'd1;
                g_cnt      <= '0;
                k_cnt      <= '0;
                err_cnt    <= '0;
                frame_ok   <= 1'b0;
                busy       <= 1'b1;
                dout_valid <= 1'b1;
                dout       <= din;
            end else begin
                case (state)
                    S_INFO: begin
                        if (din_valid) begin
                            dout_valid <= 1'b1;
                            dout       <= din;
                            if (j_cnt == 9'(J_LAST)) begin
                                j_cnt <= '0;
                                if (g_cnt == 4'(G_LAST)) begin
                                    g_cnt <= '0;
                                    k_cnt <= '0;
                                    state <= S_PARITY;
                                end else begin
                                    g_cnt <= g_cnt + 4'd1;
                                end
                            end else begin
                                j_cnt <= j_cnt + 9'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (din_valid) begin
                            err_cnt <= err_next;
                            if (k_cnt == 9'(K_LAST)) begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                frame_ok   <= (err_next == 9'd0);
                            end else begin
                                k_cnt <= k_cnt + 9'd1;
                            end
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ldpc_syndrome_check.sv
// Directed + randomized bench for ldpc_syndrome_check; parity comes from a
// matrix-level encoder model (XOR of rotated generator rows per set info bit).
module tb_ldpc_syndrome_check;
    import ldpc_syndrome_check_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din;
    logic       sof;
    logic       dout_valid;
    logic       dout;
    logic       frame_done;
    logic       frame_ok;
    logic [8:0] err_cnt;
    logic       busy;

    ldpc_syndrome_check dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .sof        (sof),
        .dout_valid (dout_valid),
        .dout       (dout),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat_err = 0;
    bit info_bits [K_INFO];
    bit par_bits  [Z];
    bit res_ok_q  [$];
    int res_err_q [$];

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            res_ok_q.push_back(frame_ok);
            res_err_q.push_back(int'(err_cnt));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] x, input int n);
        return (x >> n) | (x << (Z - n));
    endfunction

    task automatic encode();
        logic [Z-1:0] s;
        logic [Z-1:0] r;
        s = '0;
        for (int i = 0; i < K_INFO; i++) begin
            if (info_bits[i]) begin
                r = G_ROM[(i / Z) * Z +: Z];
                s = s ^ rotr(r, i % Z);
            end
        end
        for (int k = 0; k < Z; k++) par_bits[k] = s[Z-1-k];
    endtask

    task automatic rand_info();
        for (int i = 0; i < K_INFO; i++) info_bits[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc_idle();
        din_valid = 1'b0; sof = 1'b0; din = 1'b0;
        @(posedge clk); #1;
        if (dout_valid !== 1'b0 || dout !== 1'b0) lat_err++;
    endtask

    task automatic beat(input bit b, input bit s, input bit is_info);
        din_valid = 1'b1; din = b; sof = s;
        @(posedge clk); #1;
        din_valid = 1'b0; sof = 1'b0; din = 1'b0;
        if (is_info) begin
            if (dout_valid !== 1'b1 || dout !== b) lat_err++;
        end else begin
            if (dout_valid !== 1'b0 || dout !== 1'b0) lat_err++;
        end
    endtask

    task automatic gap(input int mode);
        int n;
        n = 0;
        if (mode == 1) n = 1;
        else if (mode == 2) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
        repeat (n) cyc_idle();
    endtask

    // info_stop >= 0 cuts the frame after that many info bits.
    task automatic send_frame(input int mode, input int info_stop);
        for (int i = 0; i < K_INFO; i++) begin
            if (i == info_stop) return;
            gap(mode);
            beat(info_bits[i], i == 0, 1'b1);
        end
        for (int k = 0; k < Z; k++) begin
            gap(mode);
            beat(par_bits[k], 1'b0, 1'b0);
        end
    endtask

    task automatic expect_results(input string tag, input int n, input bit ok, input int err);
        repeat (4) cyc_idle();
        check({tag, "_done_count"}, res_ok_q.size(), n);
        while (res_ok_q.size() > 0) begin
            check({tag, "_frame_ok"}, int'(res_ok_q.pop_front()), int'(ok));
            check({tag, "_err_cnt"}, res_err_q.pop_front(), err);
        end
        res_err_q.delete();
        check({tag, "_dout_stream"}, lat_err, 0);
        lat_err = 0;
    endtask

    initial begin
        logic [Z-1:0] row0;
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_ok", int'(frame_ok), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc_idle();

        // Beats without sof in IDLE are ignored.
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < K_INFO; i++) info_bits[i] = 1'b0;
        encode();
        send_frame(0, -1);
        expect_results("zero_frame", 1, 1'b1, 0);

        // Back-to-back random frames: next sof lands in the DONE cycle.
        for (int f = 0; f < 2; f++) begin
            rand_info();
            encode();
            send_frame(0, -1);
        end
        expect_results("b2b_random", 2, 1'b1, 0);

        par_bits[5] = ~par_bits[5];
        send_frame(0, -1);
        expect_results("parity5_flip", 1, 1'b0, 1);

        for (int k = 0; k < Z; k++) par_bits[k] = ~par_bits[k];
        par_bits[5] = ~par_bits[5];
        send_frame(0, -1);
        expect_results("parity_all_flip", 1, 1'b0, Z);

        for (int k = 0; k < Z; k++) par_bits[k] = ~par_bits[k];
        info_bits[0] = ~info_bits[0];
        row0 = G_ROM[Z-1:0];
        send_frame(0, -1);
        expect_results("info0_flip", 1, 1'b0, $countones(row0));
        info_bits[0] = ~info_bits[0];

        rand_info();
        encode();
        send_frame(1, -1);
        expect_results("gaps_toggle", 1, 1'b1, 0);

        rand_info();
        encode();
        send_frame(2, -1);
        expect_results("gaps_random", 1, 1'b1, 0);

        // Abort at info bit 1000, then the same frame from the start.
        send_frame(0, 1000);
        check("abort_busy", int'(busy), 1);
        send_frame(0, -1);
        expect_results("abort_restart", 1, 1'b1, 0);

        // Reset in the middle of PARITY with a nonzero running error count.
        rand_info();
        encode();
        for (int k = 0; k < 100; k++) par_bits[k] = ~par_bits[k];
        for (int i = 0; i < K_INFO; i++) beat(info_bits[i], i == 0, 1'b1);
        for (int k = 0; k < 100; k++) beat(par_bits[k], 1'b0, 1'b0);
        check("pre_rst_err_cnt", int'(err_cnt), 100);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #2;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_err_cnt", int'(err_cnt), 0);
        check("mid_rst_outputs", int'({dout_valid, dout, frame_done, frame_ok}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) par_bits[k] = ~par_bits[k];
        cyc_idle();
        send_frame(0, -1);
        expect_results("post_rst_frame", 1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
